adder_64_arb: RTL and testbench

//  Round-robin arbiter/sequencer sharing one pipelined adder_64 among NUM_REQ requesters.

---
 rtl/adder_64_arb_if.sv | 41 ++++
 rtl/adder_64_arb.sv | 134 +++++++++++++
 tb/tb_adder_64_arb.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_64_arb_if.sv
// Bundle of the request, adder and response signals around adder_64_arb.
// The slave view belongs to the arbiter; the master view belongs to requesters plus adder.
interface adder_64_arb_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*64-1:0] req_a;
  logic [NUM_REQ*64-1:0] req_b;
  logic [NUM_REQ-1:0]    req_cin;

  logic [63:0]           add_a;
  logic [63:0]           add_b;
  logic                  add_cin;
  logic                  add_en;
  logic [63:0]           add_sum;
  logic                  add_cout;
  logic                  add_vld;

  logic [NUM_REQ-1:0]    rsp_valid;
  logic [63:0]           rsp_sum;
  logic                  rsp_cout;
  logic                  busy;
  logic                  err;

  modport slave (
    input  req_valid, req_a, req_b, req_cin,
    output req_ready,
    output add_a, add_b, add_cin, add_en,
    input  add_sum, add_cout, add_vld,
    output rsp_valid, rsp_sum, rsp_cout, busy, err
  );

  modport master (
    output req_valid, req_a, req_b, req_cin,
    input  req_ready,
    input  add_a, add_b, add_cin, add_en,
    output add_sum, add_cout, add_vld,
    input  rsp_valid, rsp_sum, rsp_cout, busy, err
  );
endinterface

// File: rtl/adder_64_arb.sv
// Round-robin sequencer sharing one pipelined 64-bit adder among NUM_REQ requesters.
// A tag FIFO remembers the originator of each in-flight add so results route back in order.
module adder_64_arb #(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 4,
  parameter int MAX_OUT = 8
) (
  input  logic           clk,
  input  logic           rst,
  adder_64_arb_if.slave  bus
);
  localparam int unsigned NR    = NUM_REQ;
  localparam int          PTR_W = $clog2(NUM_REQ);
  localparam int          AW    = $clog2(MAX_OUT);
  localparam int          CNT_W = $clog2(MAX_OUT + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_OUT < ADD_LAT + 1 ||
      (MAX_OUT & (MAX_OUT - 1)) != 0) begin : g_cfg_err
    $error("adder_64_arb: illegal parameter combination");
  end

  logic [PTR_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [AW-1:0]      r_wp;
  logic [AW-1:0]      r_rp;
  logic [PTR_W-1:0]   r_tag_mem [MAX_OUT];

  logic [63:0]        r_add_a;
  logic [63:0]        r_add_b;
  logic               r_add_cin;
  logic               r_add_en;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [63:0]        r_rsp_sum;
  logic               r_rsp_cout;
  logic               r_err;

  logic               w_gnt;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [NUM_REQ-1:0] w_ready;
  int unsigned        w_idx;
  logic               w_pop;
  logic [PTR_W-1:0]   w_tag;
  logic [PTR_W-1:0]   w_ptr_nxt;

  // Rotating priority search; a slot freed by this cycle's add_vld is not reusable until next cycle.
  always_comb begin
    w_gnt     = 1'b0;
    w_gnt_idx = '0;
    w_ready   = '0;
    w_idx     = 0;
    if (!rst && r_cnt < CNT_W'(MAX_OUT)) begin
      for (int unsigned k = 0; k < NR; k++) begin
        w_idx = (32'(r_ptr) + k) % NR;
        if (!w_gnt && bus.req_valid[w_idx]) begin
          w_gnt     = 1'b1;
          w_gnt_idx = PTR_W'(w_idx);
        end
      end
    end
    if (w_gnt) begin
      w_ready[w_gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_gnt) begin
      w_ptr_nxt = (w_gnt_idx == PTR_W'(NR - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
    end
  end

  assign w_pop = bus.add_vld && (r_cnt != '0);
  assign w_tag = r_tag_mem[r_rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_add_cin   <= 1'b0;
      r_add_en    <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_ptr    <= w_ptr_nxt;
      r_add_en <= w_gnt;
      if (w_gnt) begin
        r_add_a   <= bus.req_a[64*w_gnt_idx +: 64];
        r_add_b   <= bus.req_b[64*w_gnt_idx +: 64];
        r_add_cin <= bus.req_cin[w_gnt_idx];
        r_wp      <= r_wp + AW'(1);
      end

      r_rsp_valid <= w_pop ? (NUM_REQ'(1) << w_tag) : '0;
      if (w_pop) begin
        r_rsp_sum  <= bus.add_sum;
        r_rsp_cout <= bus.add_cout;
        r_rp       <= r_rp + AW'(1);
      end

      if (bus.add_vld && r_cnt == '0) begin
        r_err <= 1'b1;
      end

      case ({w_gnt, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_gnt) begin
      r_tag_mem[r_wp] <= w_gnt_idx;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.add_a     = r_add_a;
  assign bus.add_b     = r_add_b;
  assign bus.add_cin   = r_add_cin;
  assign bus.add_en    = r_add_en;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_sum   = r_rsp_sum;
  assign bus.rsp_cout  = r_rsp_cout;
  assign bus.busy      = (r_cnt != '0);
  assign bus.err       = r_err;
endmodule

// File: tb/tb_adder_64_arb.sv
// Bench for adder_64_arb: behavioural pipelined adder, scoreboard model of the
// arbiter checked every cycle, plus directed vectors and corner-case sequences.
module tb_adder_64_arb;
  localparam int NREQ = 4;
  localparam int MOUT = 8;

  typedef struct {
    int          id;
    logic [63:0] sum;
    logic        cout;
  } exp_t;

  typedef struct {
    int          id;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spur = 1'b0;
  int   lat = 4;

  int n_cmp = 0;
  int n_bad = 0;

  adder_64_arb_if #(.NUM_REQ(NREQ)) bus ();

  adder_64_arb #(
    .NUM_REQ(NREQ),
    .ADD_LAT(4),
    .MAX_OUT(MOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Adder model: lat-stage pipeline, flushed by reset (rst_n = ~rst).
  logic [15:0] pv;
  logic [64:0] pd [16];
  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv <= {pv[14:0], bus.add_en};
    end
    pd[0] <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + 65'(bus.add_cin);
    for (int i = 1; i < 16; i++) pd[i] <= pd[i-1];
  end
  assign bus.add_vld  = pv[lat-1] | spur;
  assign bus.add_sum  = pd[lat-1][63:0];
  assign bus.add_cout = pd[lat-1][64];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard / reference model, evaluated mid-cycle.
  exp_t        exp_q[$];
  int          m_ptr = 0;
  int          m_cnt = 0;
  logic        m_err = 1'b0;
  logic        pend_v = 1'b0;
  exp_t        pend;
  logic        prev_gnt = 1'b0;
  logic [63:0] prev_a, prev_b;
  logic        prev_cin;
  logic        rst_prev = 1'b1;

  always @(negedge clk) begin : mon
    int          gi;
    logic        gnt;
    logic        pop;
    logic [3:0]  exp_rdy;
    logic [64:0] s;
    exp_t        e;
    if (rst) begin
      if (rst_prev) begin
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 0);
        chk("rst_add_en", 64'(bus.add_en), 0);
        chk("rst_add_a", bus.add_a, 0);
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_err", 64'(bus.err), 0);
        chk("rst_req_ready", 64'(bus.req_ready), 0);
      end
      m_ptr = 0; m_cnt = 0; m_err = 1'b0; pend_v = 1'b0; prev_gnt = 1'b0;
      exp_q.delete();
    end else begin
      chk("add_en", 64'(bus.add_en), 64'(prev_gnt));
      if (prev_gnt) begin
        chk("add_a", bus.add_a, prev_a);
        chk("add_b", bus.add_b, prev_b);
        chk("add_cin", 64'(bus.add_cin), 64'(prev_cin));
      end
      if (rst_prev) chk("post_rst_add_a", bus.add_a, 0);
      chk("rsp_valid", 64'(bus.rsp_valid), pend_v ? (64'd1 << pend.id) : 64'd0);
      if (pend_v) begin
        chk("rsp_sum", bus.rsp_sum, pend.sum);
        chk("rsp_cout", 64'(bus.rsp_cout), 64'(pend.cout));
      end
      chk("busy", 64'(bus.busy), 64'(m_cnt != 0));
      chk("err", 64'(bus.err), 64'(m_err));

      gnt = 1'b0; gi = 0; exp_rdy = '0;
      if (m_cnt < MOUT) begin
        for (int k = 0; k < NREQ; k++) begin
          if (!gnt && bus.req_valid[(m_ptr + k) % NREQ]) begin
            gnt = 1'b1;
            gi  = (m_ptr + k) % NREQ;
          end
        end
      end
      if (gnt) exp_rdy[gi] = 1'b1;
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));

      pop = 1'b0; pend_v = 1'b0;
      if (bus.add_vld) begin
        if (m_cnt != 0) begin
          pop = 1'b1;
          if (exp_q.size() == 0) chk("sb_underflow", 0, 1);
          else begin
            pend   = exp_q.pop_front();
            pend_v = 1'b1;
          end
        end else begin
          m_err = 1'b1;
        end
      end

      prev_gnt = gnt;
      if (gnt) begin
        prev_a   = bus.req_a[64*gi +: 64];
        prev_b   = bus.req_b[64*gi +: 64];
        prev_cin = bus.req_cin[gi];
        s = {1'b0, prev_a} + {1'b0, prev_b} + 65'(prev_cin);
        e.id = gi; e.sum = s[63:0]; e.cout = s[64];
        exp_q.push_back(e);
        m_ptr = (gi + 1) % NREQ;
      end
      m_cnt = m_cnt + (gnt ? 1 : 0) - (pop ? 1 : 0);
    end
    rst_prev = rst;
  end

  task automatic set_ops(input int i);
    bus.req_a[64*i +: 64] = {$urandom, $urandom};
    bus.req_b[64*i +: 64] = {$urandom, $urandom};
    bus.req_cin[i]        = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy && bus.rsp_valid == '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    repeat (20) @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_single(input vec_t v);
    logic ok;
    int   k;
    @(posedge clk); #1;
    bus.req_a[64*v.id +: 64] = v.a;
    bus.req_b[64*v.id +: 64] = v.b;
    bus.req_cin[v.id]        = v.cin;
    bus.req_valid[v.id]      = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready[v.id]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1 bus.req_valid[v.id] = 1'b0;
    ok = 1'b0;
    for (k = 1; k < 30; k++) begin
      @(negedge clk);
      if (k == 1) chk("vec_add_en_lat", 64'(bus.add_en), 1);
      if (bus.rsp_valid != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("rsp_timeout", 0, 1);
    else begin
      chk("vec_rsp_latency", 64'(k), 6);
      chk("vec_rsp_valid", 64'(bus.rsp_valid), 64'd1 << v.id);
      chk("vec_rsp_sum", bus.rsp_sum, v.sum);
      chk("vec_rsp_cout", 64'(bus.rsp_cout), 64'(v.cout));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[7];
    logic [3:0] g[40];
    logic       v[40];
    logic [3:0] gg;
    int         nfirst, z, idx, nrsp;

    vecs[0] = '{0, 64'h7fff_0000_ffff_0000, 64'h0000_ffff_0000_ffff, 1'b1, 64'h8000_0000_0000_0000, 1'b0};
    vecs[1] = '{2, 64'hffff_ffff_0000_0000, 64'h0000_0000_ffff_ffff, 1'b0, 64'hffff_ffff_ffff_ffff, 1'b0};
    vecs[2] = '{1, 64'hffff_ffff_ffff_ffff, 64'h0000_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0000, 1'b1};
    vecs[3] = '{3, 64'hffff_ffff_ffff_ffff, 64'hffff_ffff_ffff_ffff, 1'b1, 64'hffff_ffff_ffff_ffff, 1'b1};
    vecs[4] = '{1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0000, 1'b1};
    vecs[5] = '{0, 64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210, 1'b0, 64'hffff_ffff_ffff_ffff, 1'b0};
    vecs[6] = '{3, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0000, 1'b0};

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed single operations through the table
    for (int i = 0; i < 7; i++) begin
      wait_idle();
      run_single(vecs[i]);
    end

    // Fairness: all requesters valid from reset
    wait_idle();
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < NREQ; i++) set_ops(i);
    bus.req_valid = '1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      gg = bus.req_ready;
      if (c < 8) chk("rr_order", 64'(gg), 64'd1 << (c % NREQ));
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) if (gg[i]) set_ops(i);
    end
    bus.req_valid = '0;

    // Full FIFO with a slow adder
    wait_idle();
    lat = 12;
    @(posedge clk); #1 bus.req_valid = '1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      g[c] = bus.req_ready;
      v[c] = bus.add_vld;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) if (g[c][i]) set_ops(i);
    end
    bus.req_valid = '0;
    nfirst = 0;
    while (nfirst < 30 && g[nfirst] != '0) nfirst++;
    chk("full_burst_len", 64'(nfirst), 8);
    z = 0;
    while (nfirst + z < 30 && g[nfirst + z] == '0) z++;
    chk("full_stall_cycles", 64'(z), 6);
    idx = nfirst + z;
    if (idx < 30 && idx > 0) begin
      chk("full_vld_before_regrant", 64'(v[idx-1]), 1);
      chk("full_regrant_onehot", 64'($countones(g[idx])), 1);
    end else begin
      chk("full_regrant_missing", 64'(idx), 14);
    end
    wait_idle();
    lat = 4;

    // Spurious add_vld while idle
    @(posedge clk); #1 spur = 1'b1;
    @(posedge clk); #1 spur = 1'b0;
    nrsp = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) nrsp++;
    end
    chk("spur_err_sticky", 64'(bus.err), 1);
    chk("spur_no_rsp", 64'(nrsp), 0);
    pulse_rst();
    @(negedge clk);
    chk("spur_err_cleared", 64'(bus.err), 0);

    // Reset with three adds in flight
    wait_idle();
    @(posedge clk); #1;
    set_ops(1);
    bus.req_valid[1] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (bus.req_ready[1]) break;
      end
      @(posedge clk); #1 set_ops(1);
    end
    bus.req_valid[1] = 1'b0;
    chk("inflight_busy", 64'(bus.busy), 1);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    nrsp = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) nrsp++;
    end
    chk("rst_discard_rsp", 64'(nrsp), 0);
    run_single(vecs[0]);

    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
